// File: rtl/fetch_unit.sv
// Instruction fetch: owns PC and IR, runs a req/ack read from instruction memory.
// Latency: request goes out one cycle after ir_load; IR is written on the ack edge (min 1 cycle).
// Backpressure: ir_load is ignored while a fetch is in flight; a missing ack aborts after TIMEOUT cycles.
module fetch_unit #(
    parameter int AW      = 16,
    parameter int IW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          pc_rst,
    input  logic          pc_write,
    input  logic          pc_sel,
    input  logic          br_sel,
    input  logic          ir_load,
    input  logic [IW-1:0] im_rdata,
    input  logic          im_ack,
    output logic          im_req,
    output logic [AW-1:0] im_addr,
    output logic [IW-1:0] ir,
    output logic [3:0]    opcode,
    output logic [3:0]    mm,
    output logic [15:0]   imm,
    output logic [AW-1:0] pc_out,
    output logic          fetch_busy,
    output logic          ir_valid,
    output logic          fetch_err
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // The watchdog count holds (cycles waited - 1); the abort fires on the edge
    // that would make the request TIMEOUT cycles old.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t        state_q;
    state_t        state_d;
    logic [7:0]    wd_cnt;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_next;
    logic [AW-1:0] imm_ext;
    logic          start;
    logic          done_ok;
    logic          done_to;

    assign opcode     = ir[31:28];
    assign mm         = ir[27:24];
    assign imm        = ir[15:0];
    assign pc_out     = pc_q;
    assign fetch_busy = (state_q == WAIT);

    // State register.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and fetch start/finish strobes; pc_rst overrides all of it.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        done_ok = 1'b0;
        done_to = 1'b0;
        case (state_q)
            IDLE: begin
                if (ir_load) begin
                    start   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (im_ack) begin
                    done_ok = 1'b1;
                    state_d = IDLE;
                end else if (wd_cnt == WD_LAST) begin
                    done_to = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pc_rst) begin
            state_d = IDLE;
            start   = 1'b0;
            done_ok = 1'b0;
            done_to = 1'b0;
        end
    end

    // Next PC: increment, absolute or relative branch, all modulo 2^AW.
    always_comb begin
        imm_ext = AW'(ir[15:0]);
        pc_next = pc_q;
        if (pc_write) begin
            if (!pc_sel) begin
                pc_next = pc_q + AW'(1);
            end else if (br_sel) begin
                pc_next = imm_ext;
            end else begin
                pc_next = pc_q + imm_ext;
            end
        end
    end

    // Datapath registers: PC, request/address latch, IR, watchdog and flags.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pc_q      <= '0;
            ir        <= '0;
            im_req    <= 1'b0;
            im_addr   <= '0;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
            wd_cnt    <= '0;
        end else if (pc_rst) begin
            // Abandon any in-flight fetch; the error flag is deliberately kept.
            pc_q     <= '0;
            ir       <= '0;
            im_req   <= 1'b0;
            ir_valid <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            ir_valid <= 1'b0;
            pc_q     <= pc_next;
            if (start) begin
                // Address is latched from the pre-update PC and held for the whole fetch.
                im_addr <= pc_q;
                im_req  <= 1'b1;
                wd_cnt  <= '0;
            end
            if (done_ok) begin
                ir       <= im_rdata;
                im_req   <= 1'b0;
                ir_valid <= 1'b1;
            end else if (done_to) begin
                ir        <= '0;
                im_req    <= 1'b0;
                fetch_err <= 1'b1;
            end else if (state_q == WAIT) begin
                wd_cnt <= wd_cnt + 8'd1;
            end
        end
    end

endmodule
